// File: rtl/uart_alu_interface_if.sv
// Bus between the UART receive/transmit side, the external ALU and the
// frame collector. The collector takes the slave modport.
interface uart_alu_interface_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic             i_rx_done_tick;
  logic [DBIT-1:0]  i_rx_data;
  logic [DBIT-1:0]  i_alu_result;
  logic             i_tx_done_tick;
  logic [DBIT-1:0]  o_alu_data_a;
  logic [DBIT-1:0]  o_alu_data_b;
  logic [NB_OP-1:0] o_alu_op;
  logic [DBIT-1:0]  o_tx_data;
  logic             o_tx_start;

  modport slave (
    input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    output o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data, o_tx_start
  );

  modport master (
    output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    input  o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data, o_tx_start
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART rx, latches the ALU result
// and hands it to the UART tx. Optional: UART_ALU_TIMEOUT_EN.
module uart_alu_interface #(
  parameter int DBIT           = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic                i_clk,
  input logic                i_reset,
  uart_alu_interface_if.slave bus
);

  typedef enum logic [2:0] {
    S_SAVE_A,
    S_SAVE_B,
    S_SAVE_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_e;

  state_e           state_q, state_d;
  logic [DBIT-1:0]  a_q, a_d;
  logic [DBIT-1:0]  b_q, b_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0]  tx_q, tx_d;
  logic             expired;

  if (NB_OP < DBIT) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^bus.i_rx_data[DBIT-1:NB_OP];
  end

`ifdef UART_ALU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = (state_q == S_SAVE_B) || (state_q == S_SAVE_OP);
  assign expired = waiting && (cnt_q == CNT_LAST);

  // Idle counter: runs only while waiting for B/opcode, cleared by any tick
  always_comb begin
    cnt_d = '0;
    if (waiting && !bus.i_rx_done_tick && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  // Next state and register loads; a tick always wins over expiry
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_SAVE_A: begin
        if (bus.i_rx_done_tick) begin
          a_d     = bus.i_rx_data;
          state_d = S_SAVE_B;
        end
      end
      S_SAVE_B: begin
        if (bus.i_rx_done_tick) begin
          b_d     = bus.i_rx_data;
          state_d = S_SAVE_OP;
        end else if (expired) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
          state_d = S_SAVE_A;
        end
      end
      S_SAVE_OP: begin
        if (bus.i_rx_done_tick) begin
          op_d    = bus.i_rx_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else if (expired) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
          state_d = S_SAVE_A;
        end
      end
      S_EXEC: begin
        tx_d    = bus.i_alu_result;
        state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.i_tx_done_tick)
          state_d = S_SAVE_A;
      end
      default: begin
        state_d = S_SAVE_A;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_SAVE_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.o_alu_data_a = a_q;
  assign bus.o_alu_data_b = b_q;
  assign bus.o_alu_op     = op_q;
  assign bus.o_tx_data    = tx_q;
  assign bus.o_tx_start   = (state_q == S_SEND);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: frame table, busy drops,
// mid-frame reset and inter-byte timeout (both build variants).
module tb_uart_alu_interface;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   starts = 0;
  int   exp_starts = 0;

  always #5 clk = ~clk;

  uart_alu_interface_if #(.DBIT(8), .NB_OP(6)) bus ();

  uart_alu_interface #(
    .DBIT(8), .NB_OP(6), .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // Reference ALU
  always_comb begin
    case (bus.o_alu_op)
      6'h20:   bus.i_alu_result = bus.o_alu_data_a + bus.o_alu_data_b;
      6'h22:   bus.i_alu_result = bus.o_alu_data_a - bus.o_alu_data_b;
      6'h24:   bus.i_alu_result = bus.o_alu_data_a & bus.o_alu_data_b;
      6'h25:   bus.i_alu_result = bus.o_alu_data_a | bus.o_alu_data_b;
      6'h26:   bus.i_alu_result = bus.o_alu_data_a ^ bus.o_alu_data_b;
      default: bus.i_alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) if (bus.o_tx_start === 1'b1) starts++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] eop;
    logic [7:0] eres;
  } vec_t;

  vec_t vt[6];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Called at a negedge; leaves the tick high across one rising edge
  task automatic tick(input logic [7:0] d);
    bus.i_rx_done_tick = 1'b1;
    bus.i_rx_data      = d;
    @(negedge clk);
    bus.i_rx_done_tick = 1'b0;
  endtask

  task automatic txdone();
    bus.i_tx_done_tick = 1'b1;
    @(negedge clk);
    bus.i_tx_done_tick = 1'b0;
  endtask

  // Entered one cycle after the opcode tick (T+1)
  task automatic exec_check(input string nm, input logic [7:0] ea,
                            input logic [7:0] eb, input logic [5:0] eop,
                            input logic [7:0] eres);
    chk({nm, ".a"}, bus.o_alu_data_a, ea);
    chk({nm, ".b"}, bus.o_alu_data_b, eb);
    chk({nm, ".op"}, bus.o_alu_op, eop);
    chk({nm, ".start_t1"}, bus.o_tx_start, 0);
    @(negedge clk);
    chk({nm, ".tx"}, bus.o_tx_data, eres);
    chk({nm, ".start_t2"}, bus.o_tx_start, 1);
    @(negedge clk);
    chk({nm, ".start_t3"}, bus.o_tx_start, 0);
    exp_starts++;
    chk({nm, ".nstarts"}, starts, exp_starts);
  endtask

  initial begin
    int holdbad;
    vt[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vt[1] = '{8'hFF, 8'h01, 8'hE4, 6'h24, 8'h01};
    vt[2] = '{8'h10, 8'h30, 8'h62, 6'h22, 8'hE0};
    vt[3] = '{8'hF0, 8'h3C, 8'h25, 6'h25, 8'hFC};
    vt[4] = '{8'hAA, 8'h0F, 8'hA6, 6'h26, 8'hA5};
    vt[5] = '{8'h80, 8'h80, 8'h20, 6'h20, 8'h00};

    rst = 1'b1;
    bus.i_rx_done_tick = 1'b0;
    bus.i_rx_data      = 8'h00;
    bus.i_tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.a", bus.o_alu_data_a, 0);
    chk("rst.b", bus.o_alu_data_b, 0);
    chk("rst.op", bus.o_alu_op, 0);
    chk("rst.tx", bus.o_tx_data, 0);
    chk("rst.start", bus.o_tx_start, 0);

    // Table of complete frames, bytes back to back
    for (int i = 0; i < 6; i++) begin
      tick(vt[i].a);
      tick(vt[i].b);
      tick(vt[i].opb);
      exec_check($sformatf("vec%0d", i), vt[i].a, vt[i].b,
                 vt[i].eop, vt[i].eres);
      if (i == 1) begin
        holdbad = 0;
        for (int c = 0; c < 1000; c++) begin
          @(negedge clk);
          if (bus.o_alu_data_a !== 8'hFF || bus.o_alu_data_b !== 8'h01 ||
              bus.o_alu_op !== 6'h24 || bus.o_tx_start !== 1'b0)
            holdbad++;
        end
        chk("hold.cycles", holdbad, 0);
        chk("hold.nstarts", starts, exp_starts);
      end
      txdone();
    end

    // Bytes dropped while busy
    tick(8'h31);
    tick(8'h05);
    tick(8'h22);
    exec_check("pre_drop", 8'h31, 8'h05, 6'h22, 8'h2C);
    tick(8'h77);
    @(negedge clk);
    chk("drop.a", bus.o_alu_data_a, 8'h31);
    chk("drop.b", bus.o_alu_data_b, 8'h05);
    chk("drop.op", bus.o_alu_op, 6'h22);
    chk("drop.tx", bus.o_tx_data, 8'h2C);
    bus.i_tx_done_tick = 1'b1;
    tick(8'h77);
    bus.i_tx_done_tick = 1'b0;
    chk("drop_w.a", bus.o_alu_data_a, 8'h31);
    chk("drop_w.nstarts", starts, exp_starts);
    tick(8'h02);
    tick(8'h02);
    tick(8'h20);
    exec_check("post_drop", 8'h02, 8'h02, 6'h20, 8'h04);
    txdone();

    // Reset in the middle of a frame
    tick(8'h09);
    tick(8'h01);
    chk("mid.a", bus.o_alu_data_a, 8'h09);
    chk("mid.b", bus.o_alu_data_b, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.a", bus.o_alu_data_a, 0);
    chk("mrst.b", bus.o_alu_data_b, 0);
    chk("mrst.op", bus.o_alu_op, 0);
    chk("mrst.tx", bus.o_tx_data, 0);
    repeat (5) @(negedge clk);
    chk("mrst.nstarts", starts, exp_starts);
    tick(8'h01);
    tick(8'h01);
    tick(8'h20);
    exec_check("post_rst", 8'h01, 8'h01, 6'h20, 8'h02);
    txdone();

    // Inter-byte idle after operand A
    tick(8'h11);
    repeat (99) @(negedge clk);
    chk("to.before", bus.o_alu_data_a, 8'h11);
    @(negedge clk);
`ifdef UART_ALU_TIMEOUT_EN
    chk("to.a_clr", bus.o_alu_data_a, 0);
    chk("to.b_clr", bus.o_alu_data_b, 0);
    chk("to.op_clr", bus.o_alu_op, 0);
    tick(8'h11);
    repeat (99) @(negedge clk);
    tick(8'h33);
    chk("to.edge_a", bus.o_alu_data_a, 8'h11);
    chk("to.edge_b", bus.o_alu_data_b, 8'h33);
`else
    chk("noto.a", bus.o_alu_data_a, 8'h11);
    repeat (50) @(negedge clk);
    tick(8'h33);
    chk("noto.a2", bus.o_alu_data_a, 8'h11);
    chk("noto.b", bus.o_alu_data_b, 8'h33);
`endif
    tick(8'h20);
    exec_check("to_frame", 8'h11, 8'h33, 6'h20, 8'h44);
    txdone();
    @(negedge clk);
    chk("end.nstarts", starts, exp_starts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Downstream consumer of the UART receiver. It collects three received bytes (operand A, operand B, opcode), presents them as registered inputs to the external combinational ALU, and captures the ALU result. It then hands the result to the UART transmitter with a one-cycle start pulse and waits for the transmitter's done tick before accepting the next frame.

## Interface
- `DBIT`, 8: width of a UART data byte; also operand and result width.
- `NB_OP`, 6: opcode width; taken from the low `NB_OP` bits of the third byte.
- `TIMEOUT_CYCLES`, 50_000_000: inter-byte timeout in clock cycles. Used only with `UART_ALU_TIMEOUT_EN`. Must be ≥ 2.

Ports (name, direction, width, meaning):
- `i_clk` in 1: system clock. All logic is on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_done_tick` in 1: one-cycle pulse from the receiver; `i_rx_data` is valid in that cycle.
- `i_rx_data` in DBIT: received byte.
- `i_alu_result` in DBIT: combinational ALU output, a function of `o_alu_data_a`, `o_alu_data_b` and `o_alu_op`.
- `i_tx_done_tick` in 1: one-cycle pulse from the transmitter when its stop bit ends.
- `o_alu_data_a` out DBIT: registered operand A.
- `o_alu_data_b` out DBIT: registered operand B.
- `o_alu_op` out NB_OP: registered opcode.
- `o_tx_data` out DBIT: registered result byte for the transmitter.
- `o_tx_start` out 1: one-cycle transmit request.

## Operation
The block is an FSM with six states:
- **SAVE_A**: waits for `i_rx_done_tick`, loads `o_alu_data_a` from `i_rx_data`, moves to SAVE_B.
- **SAVE_B**: on tick, loads `o_alu_data_b`, moves to SAVE_OP.
- **SAVE_OP**: on tick, loads `o_alu_op` from `i_rx_data[NB_OP-1:0]`, moves to EXEC. Upper byte bits are discarded.
- **EXEC**: lasts exactly 1 cycle. Loads `o_tx_data` from `i_alu_result`, moves to SEND.
- **SEND**: lasts exactly 1 cycle. `o_tx_start` = 1, moves to WAIT_TX.
- **WAIT_TX**: waits for `i_tx_done_tick`, then moves to SAVE_A.

Other rules:
- `i_rx_done_tick` in EXEC, SEND or WAIT_TX is ignored. The byte is dropped and no register changes.
- `i_tx_done_tick` outside WAIT_TX is ignored.
- Operand and opcode registers hold their values until overwritten by the next frame. The ALU outputs therefore stay stable through WAIT_TX.
- There is no arithmetic inside the block. All widths are passed through unchanged.

## Timing
- Reset (synchronous): state = SAVE_A; `o_alu_data_a`, `o_alu_data_b`, `o_alu_op`, `o_tx_data` = 0; `o_tx_start` = 0. Reset applies on the first rising edge with `i_reset` high.
- Reset mid-frame or mid-transmit: partial operands are cleared and any pending `o_tx_start` is suppressed. The next byte after reset is treated as operand A.
- Opcode tick in cycle T:
  - `o_alu_op` is valid from T+1 (EXEC).
  - `o_tx_data` is valid from T+2.
  - `o_tx_start` is high only during cycle T+2.
  - State is WAIT_TX from T+3.
- `i_tx_done_tick` in cycle W (while in WAIT_TX): state is SAVE_A at W+1. A byte tick arriving in W itself is dropped; a tick in W+1 is accepted as A.
- Back-to-back `i_rx_done_tick` on consecutive cycles in SAVE_A/SAVE_B/SAVE_OP: each tick is accepted, one per cycle.
- `o_tx_start` is never asserted for more than one cycle per frame.

## Configuration
- `UART_ALU_TIMEOUT_EN` defined:
  - A cycle counter runs while the FSM is in SAVE_B or SAVE_OP. It clears on every accepted tick and on entry to those states.
  - When it reaches `TIMEOUT_CYCLES-1` without a tick, the FSM returns to SAVE_A and clears `o_alu_data_a`, `o_alu_data_b` and `o_alu_op` to 0.
  - A tick in the same cycle as the expiry takes priority: the byte is accepted and there is no abort.
- `UART_ALU_TIMEOUT_EN` undefined: no counter is built, and SAVE_B/SAVE_OP wait indefinitely.

## Test plan
- **Basic frame.** Reset, then ticks with bytes 0x05, 0x03, 0x20. The bench ALU model returns A+B for op 0x20. Expect A=0x05, B=0x03, op=0x20; `o_tx_data`=0x08; a single `o_tx_start` pulse 2 cycles after the op tick. Then tx_done returns the FSM to SAVE_A.
- **Opcode truncation and hold.** Bytes 0xFF, 0x01, 0xE4. Expect `o_alu_op`=6'h24. A, B and op stay unchanged through 1000 WAIT_TX cycles.
- **Dropped bytes while busy.** Byte 0x77 ticked during WAIT_TX, and again in the same cycle as tx_done. Expect no register change and no second start. The next frame 0x02, 0x02, 0x20 gives result 0x04.
- **Reset mid-operation.** Assert reset after bytes A=0x09 and B=0x01. Expect all outputs 0 and `o_tx_start` never asserted. The following frame 0x01, 0x01, 0x20 gives 0x02.
- **Timeout (with `UART_ALU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100).**
  - Send A=0x11, then no tick for 100 cycles: expect return to SAVE_A with A cleared to 0.
  - Repeat with a tick exactly on the expiry cycle: expect the byte accepted as B.
- **Timeout (without `UART_ALU_TIMEOUT_EN`).** Same idle stimulus: the FSM stays in SAVE_B and A stays 0x11.
